slot_tracker: RTL and testbench
===============================

SLOT_TRACKER -- requirements
Module: slot_tracker

Interface
REQ-001 SHALL have parameter Q_SIZE, default 32: number of reservation-station slots tracked.
REQ-002 SHALL have parameter S_SIZE, default 3: dispatch lanes and free ports per cycle.
REQ-003 SHALL have localparam INDEX_LEN = `CAL_IDX_LEN(Q_SIZE)`: slot index width.
REQ-004 SHALL have localparam CNT_LEN = `CAL_IDX_LEN(Q_SIZE+1)`: count width.
REQ-005 clock  in  1: single clock; all state changes on the rising edge.
REQ-006 reset_n  in  1: reset, asynchronous and active-low.
REQ-007 alloc_req  in  [S_SIZE]: lane k requests one slot this cycle.
REQ-008 free_idx  in  [S_SIZE][INDEX_LEN]: slot indices released by issue-select.
REQ-009 free_valid  in  [S_SIZE]: qualifies free_idx[k].
REQ-010 flush  in  1: release all slots.
REQ-011 alloc_idx  out  [S_SIZE][INDEX_LEN]: slot assigned to lane k.
REQ-012 alloc_grant  out  [S_SIZE]: lane k is granted alloc_idx[k] this cycle.
REQ-013 occupied  out  [Q_SIZE]: registered per-slot busy vector, feeding the issue request logic.
REQ-014 free_count  out  [CNT_LEN]: registered count of unoccupied slots.
REQ-015 full, empty  out  1 each: free_count==0 and free_count==Q_SIZE respectively.
REQ-016 error  out  1: sticky protocol-error flag (see Configuration).

Function
REQ-017 Free slots SHALL be taken from the registered occupied vector only; slots freed in cycle N become allocatable in cycle N+1.
REQ-018 Requesting lanes SHALL be served in lane order, and the j-th served lane SHALL receive the j-th lowest free index.
REQ-019 Lane k SHALL be granted only if every requesting lane below k is granted, so grants are in-order with no skips.
REQ-020 alloc_grant and alloc_idx SHALL be combinational in the same cycle, with zero latency; alloc_idx[k] SHALL be 0 when not granted.
REQ-021 On a clock edge, occupied SHALL set the bits of granted slots and clear the bits of valid free_idx slots.
REQ-022 The same slot SHALL never be both freed and allocated in one cycle, which follows from REQ-017.
REQ-023 Duplicate valid free_idx values in one cycle SHALL clear the slot once.
REQ-024 Freeing a slot that is not occupied SHALL leave state unchanged.
REQ-025 free_count SHALL equal Q_SIZE minus popcount(occupied) every cycle.
REQ-026 While full, all alloc_grant outputs SHALL be 0; frees SHALL still take effect.
REQ-027 While flush is high, all alloc_grant outputs SHALL be 0, frees SHALL be ignored, and occupied SHALL be all 0 at the next edge.
REQ-028 A free_idx value >= Q_SIZE SHALL be ignored.

Reset
REQ-029 Asserting reset_n low SHALL immediately force occupied=0, free_count=Q_SIZE, empty=1, full=0, and error=0.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding allocations; alloc_grant is 0 while reset is asserted.

Configuration
REQ-031 Macro SLOT_TRACKER_CHECK_EN enables the error flag.
REQ-032 With SLOT_TRACKER_CHECK_EN defined, error SHALL set on the edge after any of: a free of an unoccupied slot, a duplicate free index, or a free_idx value >= Q_SIZE. It SHALL remain set until reset.
REQ-033 Without SLOT_TRACKER_CHECK_EN, error SHALL be tied to 0 and no checking logic SHALL be present.

Structure
REQ-034 `CAL_IDX_LEN` and a slot index typedef SHALL live in the shared sys_defs package; no new macros are local to this block.
REQ-035 Lowest-first free-slot picking SHALL be a combinational sub-module, free_picker (Q_SIZE to S_SIZE, lowest index first). slot_tracker holds only the state and the update logic.

Verification (Q_SIZE=8, S_SIZE=3)
REQ-036 After reset, alloc_req=3'b111 -> alloc_idx={0,1,2}, alloc_grant=3'b111; next cycle occupied=8'h07, free_count=5.
REQ-037 With occupied=8'hFE and alloc_req=3'b111 -> only lane 0 is granted, with index 0; next cycle full=1 and free_count=0.
REQ-038 With occupied=8'hFF, free slot 5 and alloc_req=3'b001 in the same cycle -> no grant this cycle; next cycle lane 0 is granted index 5.
REQ-039 alloc_req=3'b101 with slots 3 and 6 free -> lane 0 gets 3 and lane 2 gets 6.
REQ-040 With flush=1, alloc_req=3'b111 and free_valid=3'b011 -> alloc_grant=0; next cycle occupied=0, empty=1, free_count=8.
REQ-041 With SLOT_TRACKER_CHECK_EN defined, free slot 4 while it is unoccupied -> error=1 from the next edge and held until reset_n is asserted low.

Source files
------------

// File: rtl/sys_defs_pkg.sv
// Shared system definitions: the index-width helper macro and the default slot index type.
`ifndef CAL_IDX_LEN
`define CAL_IDX_LEN(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package sys_defs;

    localparam int unsigned SYS_RS_SIZE = 32;

    typedef logic [`CAL_IDX_LEN(SYS_RS_SIZE)-1:0] slot_idx_t;

endpackage

// File: rtl/free_picker.sv
// Combinational free-slot picker: serves requesting lanes in lane order,
// handing the j-th served lane the j-th lowest free slot index.
module free_picker
    import sys_defs::*;
#(
    parameter int unsigned Q_SIZE = 32,
    parameter int unsigned S_SIZE = 3,
    localparam int unsigned INDEX_LEN = `CAL_IDX_LEN(Q_SIZE)
) (
    input  logic [Q_SIZE-1:0]                 free_vec,
    input  logic [S_SIZE-1:0]                 req,
    output logic [S_SIZE-1:0]                 grant,
    output logic [S_SIZE-1:0][INDEX_LEN-1:0]  idx
);

    logic [Q_SIZE-1:0]    avail;
    logic                 found;
    logic [INDEX_LEN-1:0] pos;

    // Once a lane finds nothing, every later lane finds nothing too, so grants never skip.
    always_comb begin
        avail = free_vec;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < S_SIZE; k++) begin
            found = 1'b0;
            pos   = '0;
            for (int q = 0; q < Q_SIZE; q++) begin
                if (!found && avail[q]) begin
                    found = 1'b1;
                    pos   = INDEX_LEN'(q);
                end
            end
            if (req[k] && found) begin
                grant[k]   = 1'b1;
                idx[k]     = pos;
                avail[pos] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/slot_tracker.sv
// Reservation-station slot tracker: occupancy state, free count and update logic.
// Define SLOT_TRACKER_CHECK_EN to build the sticky protocol-error checker.
module slot_tracker
    import sys_defs::*;
#(
    parameter int unsigned Q_SIZE = 32,
    parameter int unsigned S_SIZE = 3,
    localparam int unsigned INDEX_LEN = `CAL_IDX_LEN(Q_SIZE),
    localparam int unsigned CNT_LEN   = `CAL_IDX_LEN(Q_SIZE + 1)
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [S_SIZE-1:0]                 alloc_req,
    input  logic [S_SIZE-1:0][INDEX_LEN-1:0]  free_idx,
    input  logic [S_SIZE-1:0]                 free_valid,
    input  logic                              flush,
    output logic [S_SIZE-1:0][INDEX_LEN-1:0]  alloc_idx,
    output logic [S_SIZE-1:0]                 alloc_grant,
    output logic [Q_SIZE-1:0]                 occupied,
    output logic [CNT_LEN-1:0]                free_count,
    output logic                              full,
    output logic                              empty,
    output logic                              error
);

    logic [Q_SIZE-1:0]                occupied_q, occupied_d;
    logic [Q_SIZE-1:0]                set_vec, clr_vec;
    logic [CNT_LEN-1:0]               free_count_q, free_count_d;
    logic [S_SIZE-1:0]                pick_grant;
    logic [S_SIZE-1:0][INDEX_LEN-1:0] pick_idx;
    logic [S_SIZE-1:0]                free_ok;

    // Picking only looks at registered occupancy, so a slot freed now is reusable next cycle.
    free_picker #(
        .Q_SIZE (Q_SIZE),
        .S_SIZE (S_SIZE)
    ) u_free_picker (
        .free_vec (~occupied_q),
        .req      (alloc_req),
        .grant    (pick_grant),
        .idx      (pick_idx)
    );

    always_comb begin
        alloc_grant = '0;
        alloc_idx   = '0;
        if (reset_n && !flush) begin
            alloc_grant = pick_grant;
            alloc_idx   = pick_idx;
        end
    end

    always_comb begin
        for (int k = 0; k < S_SIZE; k++) begin
            free_ok[k] = free_valid[k] && !flush && (32'(free_idx[k]) < Q_SIZE);
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int k = 0; k < S_SIZE; k++) begin
            if (alloc_grant[k]) set_vec[alloc_idx[k]] = 1'b1;
            if (free_ok[k])     clr_vec[free_idx[k]]  = 1'b1;
        end
        occupied_d   = flush ? '0 : ((occupied_q & ~clr_vec) | set_vec);
        free_count_d = CNT_LEN'(Q_SIZE);
        for (int q = 0; q < Q_SIZE; q++) begin
            if (occupied_d[q]) free_count_d = free_count_d - CNT_LEN'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occupied_q   <= '0;
            free_count_q <= CNT_LEN'(Q_SIZE);
        end else begin
            occupied_q   <= occupied_d;
            free_count_q <= free_count_d;
        end
    end

    assign occupied   = occupied_q;
    assign free_count = free_count_q;
    assign full       = (free_count_q == '0);
    assign empty      = (free_count_q == CNT_LEN'(Q_SIZE));

`ifdef SLOT_TRACKER_CHECK_EN
    logic error_q, error_d, bad_free;

    // Flags out-of-range frees, frees of idle slots and the same index freed twice in a cycle.
    always_comb begin
        bad_free = 1'b0;
        for (int k = 0; k < S_SIZE; k++) begin
            if (free_valid[k]) begin
                if (32'(free_idx[k]) >= Q_SIZE) begin
                    bad_free = 1'b1;
                end else if (!occupied_q[free_idx[k]]) begin
                    bad_free = 1'b1;
                end
                for (int m = 0; m < k; m++) begin
                    if (free_valid[m] && (free_idx[m] == free_idx[k])) bad_free = 1'b1;
                end
            end
        end
        error_d = error_q | bad_free;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_slot_tracker.sv
// Self-checking bench for slot_tracker (Q_SIZE=8, S_SIZE=3): directed scenarios plus a
// scoreboard fed by a behavioural occupancy model.
module tb_slot_tracker;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic [2:0]       alloc_req = '0;
    logic [2:0][2:0]  free_idx = '0;
    logic [2:0]       free_valid = '0;
    logic             flush = 1'b0;
    logic [2:0][2:0]  alloc_idx;
    logic [2:0]       alloc_grant;
    logic [7:0]       occupied;
    logic [3:0]       free_count;
    logic             full, empty, error;

    always #5 clock = ~clock;

    slot_tracker #(
        .Q_SIZE (8),
        .S_SIZE (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc_req   (alloc_req),
        .free_idx    (free_idx),
        .free_valid  (free_valid),
        .flush       (flush),
        .alloc_idx   (alloc_idx),
        .alloc_grant (alloc_grant),
        .occupied    (occupied),
        .free_count  (free_count),
        .full        (full),
        .empty       (empty),
        .error       (error)
    );

    typedef struct {
        logic [2:0]      grant;
        logic [2:0][2:0] idx;
        logic [7:0]      occ;
        logic [3:0]      cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_occ = '0;
    int         n_vec = 0;
    int         n_err = 0;

    // Model: list free slots ascending, hand them out to requesting lanes in order.
    task automatic drive(input logic [2:0] req, input logic [2:0] fv,
                         input logic [2:0][2:0] fi, input logic fl);
        exp_t       e;
        int         free_list[$];
        int         served;
        logic [7:0] nxt;
        @(negedge clock);
        e.grant = '0;
        e.idx   = '0;
        served  = 0;
        for (int q = 0; q < 8; q++) if (!m_occ[q]) free_list.push_back(q);
        if (!fl) begin
            for (int k = 0; k < 3; k++) begin
                if (req[k] && served < free_list.size()) begin
                    e.grant[k] = 1'b1;
                    e.idx[k]   = 3'(free_list[served]);
                    served++;
                end
            end
        end
        nxt = m_occ;
        if (fl) begin
            nxt = '0;
        end else begin
            for (int k = 0; k < 3; k++) if (fv[k]) nxt[fi[k]] = 1'b0;
            for (int k = 0; k < 3; k++) if (e.grant[k]) nxt[e.idx[k]] = 1'b1;
        end
        e.occ = nxt;
        e.cnt = 4'(8 - $countones(nxt));
        m_occ = nxt;
        exp_q.push_back(e);
        alloc_req  = req;
        free_valid = fv;
        free_idx   = fi;
        flush      = fl;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (alloc_grant !== e.grant || alloc_idx !== e.idx) begin
                    n_err++;
                    $display("FAIL sb_alloc t=%0t grant=%b idx=%h, expected grant=%b idx=%h",
                             $time, alloc_grant, alloc_idx, e.grant, e.idx);
                end
                @(posedge clock);
                #1;
                n_vec++;
                if (occupied !== e.occ || free_count !== e.cnt || full !== (e.cnt == 4'd0) ||
                    empty !== (e.cnt == 4'd8)) begin
                    n_err++;
                    $display("FAIL sb_state t=%0t occ=%h cnt=%0d full=%b empty=%b, expected occ=%h cnt=%0d",
                             $time, occupied, free_count, full, empty, e.occ, e.cnt);
                end
`ifndef SLOT_TRACKER_CHECK_EN
                if (error !== 1'b0) begin
                    n_err++;
                    $display("FAIL error_tied t=%0t error=%b, expected 0", $time, error);
                end
`endif
            end
        end
    end

    task automatic test_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        alloc_req  = 3'b111;
        free_valid = '0;
        free_idx   = '0;
        flush      = 1'b0;
        m_occ      = '0;
        #1;
        n_vec++;
        if ({occupied, free_count, empty, full, error, alloc_grant} !==
            {8'h00, 4'd8, 1'b1, 1'b0, 1'b0, 3'b000}) begin
            n_err++;
            $display("FAIL reset occ=%h cnt=%0d empty=%b full=%b error=%b grant=%b, expected 00 8 1 0 0 000",
                     occupied, free_count, empty, full, error, alloc_grant);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        alloc_req = '0;
    endtask

    task automatic test_fill();
        drive(3'b111, 3'b000, '0, 1'b0);
        #3;
        n_vec++;
        if (alloc_grant !== 3'b111 || alloc_idx !== {3'd2, 3'd1, 3'd0}) begin
            n_err++;
            $display("FAIL fill_alloc grant=%b idx=%h, expected 111 idx=%h",
                     alloc_grant, alloc_idx, {3'd2, 3'd1, 3'd0});
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (occupied !== 8'h07 || free_count !== 4'd5) begin
            n_err++;
            $display("FAIL fill_state occ=%h cnt=%0d, expected 07 5", occupied, free_count);
        end
    endtask

    task automatic test_full();
        drive(3'b111, 3'b000, '0, 1'b0);
        drive(3'b011, 3'b000, '0, 1'b0);
        drive(3'b000, 3'b001, {3'd0, 3'd0, 3'd0}, 1'b0);
        drive(3'b111, 3'b000, '0, 1'b0);
        #3;
        n_vec++;
        if (alloc_grant !== 3'b001 || alloc_idx !== 9'h000) begin
            n_err++;
            $display("FAIL last_slot grant=%b idx=%h, expected 001 idx=000", alloc_grant, alloc_idx);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (full !== 1'b1 || free_count !== 4'd0) begin
            n_err++;
            $display("FAIL full_state full=%b cnt=%0d, expected 1 0", full, free_count);
        end
    endtask

    task automatic test_free_then_alloc();
        drive(3'b001, 3'b001, {3'd0, 3'd0, 3'd5}, 1'b0);
        #3;
        n_vec++;
        if (alloc_grant !== 3'b000) begin
            n_err++;
            $display("FAIL full_no_grant grant=%b, expected 000", alloc_grant);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (occupied !== 8'hDF || full !== 1'b0) begin
            n_err++;
            $display("FAIL free_in_full occ=%h full=%b, expected DF 0", occupied, full);
        end
        drive(3'b001, 3'b000, '0, 1'b0);
        #3;
        n_vec++;
        if (alloc_grant !== 3'b001 || alloc_idx !== {3'd0, 3'd0, 3'd5}) begin
            n_err++;
            $display("FAIL reuse_next grant=%b idx=%h, expected 001 idx=005", alloc_grant, alloc_idx);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_lane_skip();
        drive(3'b000, 3'b011, {3'd0, 3'd6, 3'd3}, 1'b0);
        drive(3'b101, 3'b000, '0, 1'b0);
        #3;
        n_vec++;
        if (alloc_grant !== 3'b101 || alloc_idx !== {3'd6, 3'd0, 3'd3}) begin
            n_err++;
            $display("FAIL lane_skip grant=%b idx=%h, expected 101 idx=%h",
                     alloc_grant, alloc_idx, {3'd6, 3'd0, 3'd3});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_dup_free();
        drive(3'b000, 3'b011, {3'd0, 3'd2, 3'd2}, 1'b0);
        @(posedge clock);
        #1;
        n_vec++;
        if (occupied !== 8'hFB || free_count !== 4'd1) begin
            n_err++;
            $display("FAIL dup_free occ=%h cnt=%0d, expected FB 1", occupied, free_count);
        end
    endtask

    task automatic test_flush();
        drive(3'b111, 3'b011, {3'd0, 3'd0, 3'd1}, 1'b1);
        #3;
        n_vec++;
        if (alloc_grant !== 3'b000 || alloc_idx !== 9'h000) begin
            n_err++;
            $display("FAIL flush_grant grant=%b idx=%h, expected 000 idx=000", alloc_grant, alloc_idx);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (occupied !== 8'h00 || empty !== 1'b1 || free_count !== 4'd8) begin
            n_err++;
            $display("FAIL flush_state occ=%h empty=%b cnt=%0d, expected 00 1 8",
                     occupied, empty, free_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0][2:0] fi;
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < 3; k++) fi[k] = 3'($urandom_range(0, 7));
            drive(3'($urandom), 3'($urandom), fi, ($urandom_range(0, 19) == 0));
        end
        @(posedge clock);
        #2;
    endtask

`ifdef SLOT_TRACKER_CHECK_EN
    task automatic test_error();
        drive(3'b000, 3'b001, {3'd0, 3'd0, 3'd4}, 1'b0);
        #3;
        n_vec++;
        if (error !== 1'b0) begin
            n_err++;
            $display("FAIL error_early error=%b, expected 0", error);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (error !== 1'b1) begin
            n_err++;
            $display("FAIL error_set error=%b, expected 1", error);
        end
        drive(3'b001, 3'b000, '0, 1'b0);
        drive(3'b000, 3'b000, '0, 1'b0);
        @(posedge clock);
        #1;
        n_vec++;
        if (error !== 1'b1) begin
            n_err++;
            $display("FAIL error_sticky error=%b, expected 1", error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_reset();
        test_fill();
        test_full();
        test_free_then_alloc();
        test_lane_skip();
        test_dup_free();
        test_flush();
        test_back_to_back();
        test_reset();
`ifdef SLOT_TRACKER_CHECK_EN
        test_error();
        test_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
